// File: rtl/bp_nonsynth_dma_mem.sv
// Behavioural multi-channel DMA memory model: serves bsg_cache DMA packets
// from an internal word array with round-robin channel arbitration,
// programmable read latency, range checking and per-channel packet counters.
module bp_nonsynth_dma_mem #(
    parameter int unsigned num_dma_p      = 1,
    parameter int unsigned daddr_width_p  = 32,
    parameter int unsigned fill_width_p   = 64,
    parameter int unsigned block_width_p  = 512,
    parameter int unsigned mem_bytes_p    = 2**20,
    parameter logic [daddr_width_p-1:0] base_addr_p = daddr_width_p'(32'h8000_0000),
    parameter int unsigned read_latency_p = 4,
    parameter int unsigned ctr_width_p    = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_dma_p*(daddr_width_p+1)-1:0] dma_pkt_i,
    input  logic [num_dma_p-1:0]                   dma_pkt_v_i,
    output logic [num_dma_p-1:0]                   dma_pkt_yumi_o,
    output logic [num_dma_p*fill_width_p-1:0]      dma_data_o,
    output logic [num_dma_p-1:0]                   dma_data_v_o,
    input  logic [num_dma_p-1:0]                   dma_data_ready_and_i,
    input  logic [num_dma_p*fill_width_p-1:0]      dma_data_i,
    input  logic [num_dma_p-1:0]                   dma_data_v_i,
    output logic [num_dma_p-1:0]                   dma_data_yumi_o,
    output logic                                   err_o,
    output logic [num_dma_p*ctr_width_p-1:0]       req_count_o
);

    localparam int unsigned pkt_w_lp       = daddr_width_p + 1;
    localparam int unsigned fill_bytes_lp  = fill_width_p / 8;
    localparam int unsigned block_bytes_lp = block_width_p / 8;
    localparam int unsigned beats_lp       = block_width_p / fill_width_p;
    localparam int unsigned mem_words_lp   = mem_bytes_p / fill_bytes_lp;
    localparam int unsigned ch_w_lp        = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
    localparam int unsigned beat_w_lp      = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int unsigned lat_w_lp       = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;
    localparam int unsigned word_w_lp      = (mem_words_lp > 1) ? $clog2(mem_words_lp) : 1;
    localparam int unsigned blk_shift_lp   = $clog2(block_bytes_lp);
    localparam int unsigned fill_shift_lp  = $clog2(fill_bytes_lp);

    localparam logic [daddr_width_p:0] mem_bytes_lp = (daddr_width_p+1)'(mem_bytes_p);
    localparam logic [beat_w_lp-1:0]   last_beat_lp = beat_w_lp'(beats_lp - 1);
    localparam logic [lat_w_lp-1:0]    last_lat_lp  = lat_w_lp'(read_latency_p - 1);

    typedef enum logic [1:0] {
        e_ready,
        e_wait,
        e_read,
        e_write
    } state_e;

    // Per-channel views of the flattened buses
    logic [num_dma_p-1:0][pkt_w_lp-1:0]     pkt_arr;
    logic [num_dma_p-1:0][fill_width_p-1:0] wdata_arr;
    logic [num_dma_p-1:0][fill_width_p-1:0] rdata_arr_c;

    assign pkt_arr   = dma_pkt_i;
    assign wdata_arr = dma_data_i;

    state_e                               state_q, state_d;
    logic [ch_w_lp-1:0]                   ch_q, ch_d;
    logic [ch_w_lp-1:0]                   ptr_q, ptr_d;
    logic [beat_w_lp-1:0]                 beat_q, beat_d;
    logic [lat_w_lp-1:0]                  lat_q, lat_d;
    logic [word_w_lp-1:0]                 word_base_q, word_base_d;
    logic                                 oor_q, oor_d;
    logic                                 err_q, err_d;
    logic [num_dma_p-1:0][ctr_width_p-1:0] req_count_q, req_count_d;

    logic [fill_width_p-1:0] mem_r [mem_words_lp];

    logic                     sel_v_c;
    logic [ch_w_lp-1:0]       sel_c;
    logic [ch_w_lp-1:0]       sel_next_c;
    logic                     sel_wnr_c;
    logic [daddr_width_p-1:0] sel_addr_c;
    logic [daddr_width_p-1:0] sel_aligned_c;
    logic [daddr_width_p-1:0] sel_off_c;
    logic                     sel_oor_c;
    logic [word_w_lp-1:0]     idx_c;
    logic [fill_width_p-1:0]  rd_word_c;
    logic [num_dma_p-1:0]     pkt_yumi_c;
    logic [num_dma_p-1:0]     data_v_c;
    logic [num_dma_p-1:0]     data_yumi_c;
    logic                     mem_we_c;

    // Round-robin pick: lowest-index valid channel at or after the pointer
    always_comb begin
        int unsigned idx;
        sel_v_c = 1'b0;
        sel_c   = '0;
        idx     = 0;
        for (int unsigned i = 0; i < num_dma_p; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= num_dma_p) begin
                idx = idx - num_dma_p;
            end
            if (!sel_v_c && dma_pkt_v_i[ch_w_lp'(idx)]) begin
                sel_v_c = 1'b1;
                sel_c   = ch_w_lp'(idx);
            end
        end
        idx = 32'(sel_c) + 1;
        if (idx >= num_dma_p) begin
            idx = 0;
        end
        sel_next_c = ch_w_lp'(idx);
    end

    // Decode the selected packet: block alignment, word offset and range check
    always_comb begin
        sel_wnr_c     = pkt_arr[sel_c][pkt_w_lp-1];
        sel_addr_c    = pkt_arr[sel_c][daddr_width_p-1:0];
        sel_aligned_c = (sel_addr_c >> blk_shift_lp) << blk_shift_lp;
        sel_off_c     = sel_aligned_c - base_addr_p;
        sel_oor_c     = (sel_addr_c < base_addr_p)
                     || ({1'b0, sel_addr_c - base_addr_p} >= mem_bytes_lp);
    end

    // Current beat's word address and read data (zero for out-of-range packets)
    always_comb begin
        idx_c     = word_base_q + word_w_lp'(beat_q);
        rd_word_c = oor_q ? '0 : mem_r[idx_c];
    end

    // Transfer FSM: next state, datapath updates and handshake outputs
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        lat_d       = lat_q;
        word_base_d = word_base_q;
        oor_d       = oor_q;
        err_d       = err_q;
        req_count_d = req_count_q;
        pkt_yumi_c  = '0;
        data_v_c    = '0;
        data_yumi_c = '0;
        rdata_arr_c = '0;
        mem_we_c    = 1'b0;

        if (!reset_i) begin
            case (state_q)
                e_ready: begin
                    if (sel_v_c) begin
                        pkt_yumi_c[sel_c]  = 1'b1;
                        ch_d               = sel_c;
                        ptr_d              = sel_next_c;
                        beat_d             = '0;
                        lat_d              = '0;
                        word_base_d        = word_w_lp'(sel_off_c >> fill_shift_lp);
                        oor_d              = sel_oor_c;
                        err_d              = err_q | sel_oor_c;
                        req_count_d[sel_c] = req_count_q[sel_c] + ctr_width_p'(1);
                        if (sel_wnr_c) begin
                            state_d = e_write;
                        end else if (read_latency_p > 0) begin
                            state_d = e_wait;
                        end else begin
                            state_d = e_read;
                        end
                    end
                end
                e_wait: begin
                    if (lat_q == last_lat_lp) begin
                        state_d = e_read;
                    end else begin
                        lat_d = lat_q + lat_w_lp'(1);
                    end
                end
                e_read: begin
                    data_v_c[ch_q]    = 1'b1;
                    rdata_arr_c[ch_q] = rd_word_c;
                    if (dma_data_ready_and_i[ch_q]) begin
                        if (beat_q == last_beat_lp) begin
                            state_d = e_ready;
                        end else begin
                            beat_d = beat_q + beat_w_lp'(1);
                        end
                    end
                end
                e_write: begin
                    data_yumi_c[ch_q] = dma_data_v_i[ch_q];
                    if (dma_data_v_i[ch_q]) begin
                        mem_we_c = !oor_q;
                        if (beat_q == last_beat_lp) begin
                            state_d = e_ready;
                        end else begin
                            beat_d = beat_q + beat_w_lp'(1);
                        end
                    end
                end
                default: state_d = e_ready;
            endcase
        end
    end

    // State and control registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            ch_q        <= '0;
            ptr_q       <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            word_base_q <= '0;
            oor_q       <= 1'b0;
            err_q       <= 1'b0;
            req_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            word_base_q <= word_base_d;
            oor_q       <= oor_d;
            err_q       <= err_d;
            req_count_q <= req_count_d;
        end
    end

    // Backing store, deliberately not reset so contents survive reset_i
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_r[idx_c] <= wdata_arr[ch_q];
        end
    end

    assign dma_pkt_yumi_o  = pkt_yumi_c;
    assign dma_data_v_o    = data_v_c;
    assign dma_data_o      = rdata_arr_c;
    assign dma_data_yumi_o = data_yumi_c;
    assign err_o           = err_q;
    assign req_count_o     = req_count_q;

endmodule

// File: tb/tb_bp_nonsynth_dma_mem.sv
// Directed bench for bp_nonsynth_dma_mem: one instance per configuration
// (1 channel latency 4, 1 channel latency 0, 3 channels latency 0).
module tb_bp_nonsynth_dma_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: 1 channel, read latency 4, 1 MiB
    logic [32:0] a_pkt;
    logic        a_pkt_v, a_pkt_yumi, a_data_v_o, a_ready, a_data_v_i, a_data_yumi, a_err;
    logic [63:0] a_data_o, a_data_i;
    logic [15:0] a_cnt;

    bp_nonsynth_dma_mem #(.num_dma_p(1), .read_latency_p(4)) u_dut_a (
        .clk_i(clk), .reset_i(rst),
        .dma_pkt_i(a_pkt), .dma_pkt_v_i(a_pkt_v), .dma_pkt_yumi_o(a_pkt_yumi),
        .dma_data_o(a_data_o), .dma_data_v_o(a_data_v_o), .dma_data_ready_and_i(a_ready),
        .dma_data_i(a_data_i), .dma_data_v_i(a_data_v_i), .dma_data_yumi_o(a_data_yumi),
        .err_o(a_err), .req_count_o(a_cnt)
    );

    // Instance B: 1 channel, read latency 0, 4 KiB
    logic [32:0] b_pkt;
    logic        b_pkt_v, b_pkt_yumi, b_data_v_o, b_ready, b_data_v_i, b_data_yumi, b_err;
    logic [63:0] b_data_o, b_data_i;
    logic [15:0] b_cnt;

    bp_nonsynth_dma_mem #(.num_dma_p(1), .read_latency_p(0), .mem_bytes_p(4096)) u_dut_b (
        .clk_i(clk), .reset_i(rst),
        .dma_pkt_i(b_pkt), .dma_pkt_v_i(b_pkt_v), .dma_pkt_yumi_o(b_pkt_yumi),
        .dma_data_o(b_data_o), .dma_data_v_o(b_data_v_o), .dma_data_ready_and_i(b_ready),
        .dma_data_i(b_data_i), .dma_data_v_i(b_data_v_i), .dma_data_yumi_o(b_data_yumi),
        .err_o(b_err), .req_count_o(b_cnt)
    );

    // Instance C: 3 channels, read latency 0, 4 KiB
    logic [98:0]  c_pkt;
    logic [2:0]   c_pkt_v, c_pkt_yumi, c_data_v_o, c_ready, c_data_v_i, c_data_yumi;
    logic [191:0] c_data_o, c_data_i;
    logic         c_err;
    logic [47:0]  c_cnt;

    bp_nonsynth_dma_mem #(.num_dma_p(3), .read_latency_p(0), .mem_bytes_p(4096)) u_dut_c (
        .clk_i(clk), .reset_i(rst),
        .dma_pkt_i(c_pkt), .dma_pkt_v_i(c_pkt_v), .dma_pkt_yumi_o(c_pkt_yumi),
        .dma_data_o(c_data_o), .dma_data_v_o(c_data_v_o), .dma_data_ready_and_i(c_ready),
        .dma_data_i(c_data_i), .dma_data_v_i(c_data_v_i), .dma_data_yumi_o(c_data_yumi),
        .err_o(c_err), .req_count_o(c_cnt)
    );

    // Write one 8-beat packet into instance A
    task automatic a_write(input logic [31:0] addr, input logic [7:0][63:0] d, input string nm);
        @(negedge clk);
        a_pkt = {1'b1, addr}; a_pkt_v = 1'b1; #1;
        checks++;
        if (a_pkt_yumi !== 1'b1) begin
            errors++; $display("FAIL %s pkt_yumi got %b want 1", nm, a_pkt_yumi);
        end
        @(negedge clk);
        a_pkt_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_data_i = d[i]; a_data_v_i = 1'b1; #1;
            checks++;
            if (a_data_yumi !== 1'b1) begin
                errors++; $display("FAIL %s data_yumi beat %0d got %b want 1", nm, i, a_data_yumi);
            end
            @(negedge clk);
        end
        a_data_v_i = 1'b0;
    endtask

    // Read one packet from instance A, checking latency, 8 beats and no 9th beat
    task automatic a_read(input logic [31:0] addr, input logic [7:0][63:0] e, input int lat,
                          input string nm);
        int n;
        @(negedge clk);
        a_pkt = {1'b0, addr}; a_pkt_v = 1'b1; a_ready = 1'b1; #1;
        checks++;
        if (a_pkt_yumi !== 1'b1) begin
            errors++; $display("FAIL %s pkt_yumi got %b want 1", nm, a_pkt_yumi);
        end
        @(negedge clk);
        a_pkt_v = 1'b0; n = 1; #1;
        while (a_data_v_o !== 1'b1 && n < 40) begin
            @(negedge clk); n++; #1;
        end
        checks++;
        if (n !== lat) begin
            errors++; $display("FAIL %s latency got %0d want %0d", nm, n, lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_data_v_o !== 1'b1 || a_data_o !== e[i]) begin
                errors++;
                $display("FAIL %s beat %0d got v=%b %h want v=1 %h", nm, i, a_data_v_o, a_data_o, e[i]);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (a_data_v_o !== 1'b0) begin
            errors++; $display("FAIL %s extra beat got v=%b want 0", nm, a_data_v_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_pkt = {1'b0, 32'h8000_0000}; a_pkt_v = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (a_pkt_yumi !== 1'b0 || a_data_v_o !== 1'b0) begin
            errors++; $display("FAIL reset_hold yumi=%b v=%b want 0 0", a_pkt_yumi, a_data_v_o);
        end
        @(negedge clk);
        rst = 1'b0; a_pkt_v = 1'b0; #1;
        checks++;
        if (a_err !== 1'b0 || a_cnt !== 16'd0 || a_data_o !== 64'd0 || a_data_yumi !== 1'b0) begin
            errors++;
            $display("FAIL reset_a err=%b cnt=%h data=%h dyumi=%b want all 0", a_err, a_cnt, a_data_o, a_data_yumi);
        end
        checks++;
        if (b_err !== 1'b0 || b_cnt !== 16'd0 || b_data_v_o !== 1'b0) begin
            errors++; $display("FAIL reset_b err=%b cnt=%h v=%b want all 0", b_err, b_cnt, b_data_v_o);
        end
        checks++;
        if (c_err !== 1'b0 || c_cnt !== 48'd0 || c_data_v_o !== 3'd0 || c_pkt_yumi !== 3'd0) begin
            errors++; $display("FAIL reset_c err=%b cnt=%h v=%b yumi=%b want all 0", c_err, c_cnt, c_data_v_o, c_pkt_yumi);
        end
    endtask

    task automatic test_write_read();
        logic [7:0][63:0] d;
        for (int i = 0; i < 8; i++) d[i] = 64'h11 * 64'(i);
        a_write(32'h8000_0040, d, "wr_40");
        a_read(32'h8000_0040, d, 5, "rd_40");
        checks++;
        if (a_cnt !== 16'd2 || a_err !== 1'b0) begin
            errors++; $display("FAIL wr_rd_count cnt=%0d err=%b want 2 0", a_cnt, a_err);
        end
    endtask

    task automatic test_unaligned();
        logic [7:0][63:0] d;
        for (int i = 0; i < 8; i++) d[i] = 64'h11 * 64'(i);
        a_read(32'h8000_0058, d, 5, "rd_unaligned");
    endtask

    task automatic test_lat0_stall();
        logic [7:0][63:0] d;
        for (int i = 0; i < 8; i++) d[i] = 64'hB0B0_0000_0000_0000 + 64'(i);
        @(negedge clk);
        b_pkt = {1'b1, 32'h8000_0000}; b_pkt_v = 1'b1; #1;
        checks++;
        if (b_pkt_yumi !== 1'b1) begin errors++; $display("FAIL b_wr_yumi got %b want 1", b_pkt_yumi); end
        @(negedge clk);
        b_pkt_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_data_i = d[i]; b_data_v_i = 1'b1; #1;
            checks++;
            if (b_data_yumi !== 1'b1) begin errors++; $display("FAIL b_wr_beat %0d got %b want 1", i, b_data_yumi); end
            @(negedge clk);
        end
        b_data_v_i = 1'b0;
        @(negedge clk);
        b_pkt = {1'b0, 32'h8000_0000}; b_pkt_v = 1'b1; b_ready = 1'b1; #1;
        checks++;
        if (b_pkt_yumi !== 1'b1 || b_data_v_o !== 1'b0) begin
            errors++; $display("FAIL b_rd_accept yumi=%b v=%b want 1 0", b_pkt_yumi, b_data_v_o);
        end
        @(negedge clk);
        b_pkt_v = 1'b0; #1;
        checks++;
        if (b_data_v_o !== 1'b1 || b_data_o !== d[0]) begin
            errors++; $display("FAIL b_lat0 beat0 got v=%b %h want v=1 %h", b_data_v_o, b_data_o, d[0]);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            b_ready = 1'b0; #1;
            checks++;
            if (b_data_v_o !== 1'b1 || b_data_o !== d[1]) begin
                errors++; $display("FAIL b_stall %0d got v=%b %h want v=1 %h", s, b_data_v_o, b_data_o, d[1]);
            end
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            b_ready = 1'b1; #1;
            checks++;
            if (b_data_v_o !== 1'b1 || b_data_o !== d[i]) begin
                errors++; $display("FAIL b_beat %0d got v=%b %h want v=1 %h", i, b_data_v_o, b_data_o, d[i]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (b_data_v_o !== 1'b0 || b_cnt !== 16'd2 || b_err !== 1'b0) begin
            errors++; $display("FAIL b_done v=%b cnt=%0d err=%b want 0 2 0", b_data_v_o, b_cnt, b_err);
        end
    endtask

    task automatic test_round_robin();
        int k;
        int last;
        k = 0; last = 0;
        @(negedge clk);
        c_pkt = {1'b0, 32'h8000_0100, 1'b0, 32'h8000_0040, 1'b0, 32'h8000_0000};
        c_pkt_v = 3'b111; c_ready = 3'b111; c_data_v_i = 3'b111;
        for (int cyc = 0; cyc < 200 && k < 6; cyc++) begin
            #1;
            if (c_pkt_yumi !== 3'b000) begin
                checks++;
                if (c_pkt_yumi !== 3'(1 << (k % 3))) begin
                    errors++; $display("FAIL rr_order pkt %0d got %b want %b", k, c_pkt_yumi, 3'(1 << (k % 3)));
                end
                last = k % 3;
                k++;
            end
            if (c_data_v_o !== 3'b000) begin
                checks++;
                if (c_data_v_o !== 3'(1 << last)) begin
                    errors++; $display("FAIL rr_data_v got %b want %b", c_data_v_o, 3'(1 << last));
                end
            end
            checks++;
            if (c_data_yumi !== 3'b000) begin
                errors++; $display("FAIL rr_data_yumi got %b want 000", c_data_yumi);
            end
            @(negedge clk);
        end
        c_pkt_v = 3'b000; c_data_v_i = 3'b000;
        checks++;
        if (k !== 6) begin errors++; $display("FAIL rr_timeout packets got %0d want 6", k); end
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (c_cnt !== {16'd2, 16'd2, 16'd2}) begin
            errors++; $display("FAIL rr_counts got %h want %h", c_cnt, {16'd2, 16'd2, 16'd2});
        end
        checks++;
        if (c_data_v_o !== 3'b000 || c_data_o !== 192'd0 || c_err !== 1'b0) begin
            errors++; $display("FAIL rr_idle v=%b data=%h err=%b want 0", c_data_v_o, c_data_o, c_err);
        end
    endtask

    task automatic test_range();
        logic [7:0][63:0] d;
        logic [7:0][63:0] z;
        logic [7:0][63:0] f;
        for (int i = 0; i < 8; i++) begin
            d[i] = 64'hA0 + 64'(i);
            z[i] = 64'd0;
            f[i] = 64'hFFFF_FFFF_FFFF_FF00 + 64'(i);
        end
        a_write(32'h8000_0000, d, "wr_base");
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL range_pre err got %b want 0", a_err); end
        a_read(32'h7FFF_FFC0, z, 5, "rd_below_base");
        checks++;
        if (a_err !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", a_err); end
        a_write(32'h8010_0000, f, "wr_past_end");
        a_read(32'h8000_0000, d, 5, "rd_base_after_oor");
        checks++;
        if (a_err !== 1'b1 || a_cnt !== 16'd7) begin
            errors++; $display("FAIL range_post err=%b cnt=%0d want 1 7", a_err, a_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0][63:0] d;
        logic [7:0][63:0] e;
        for (int i = 0; i < 8; i++) begin
            d[i] = 64'hD0 + 64'(i);
            e[i] = (i < 3) ? 64'hC0 + 64'(i) : d[i];
        end
        a_write(32'h8000_0080, d, "wr_80");
        @(negedge clk);
        a_pkt = {1'b1, 32'h8000_0080}; a_pkt_v = 1'b1; #1;
        checks++;
        if (a_pkt_yumi !== 1'b1) begin errors++; $display("FAIL midrst_yumi got %b want 1", a_pkt_yumi); end
        @(negedge clk);
        a_pkt_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_data_i = 64'hC0 + 64'(i); a_data_v_i = 1'b1; #1;
            checks++;
            if (a_data_yumi !== 1'b1) begin errors++; $display("FAIL midrst_beat %0d got %b want 1", i, a_data_yumi); end
            @(negedge clk);
        end
        a_data_v_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; a_data_i = 64'hDEAD_BEEF; a_data_v_i = 1'b1; #1;
        checks++;
        if (a_data_yumi !== 1'b0 || a_pkt_yumi !== 1'b0 || a_data_v_o !== 1'b0 || a_data_o !== 64'd0) begin
            errors++;
            $display("FAIL midrst_outputs dyumi=%b pyumi=%b v=%b data=%h want 0", a_data_yumi, a_pkt_yumi, a_data_v_o, a_data_o);
        end
        checks++;
        if (a_err !== 1'b0 || a_cnt !== 16'd0) begin
            errors++; $display("FAIL midrst_clear err=%b cnt=%0d want 0 0", a_err, a_cnt);
        end
        a_data_v_i = 1'b0;
        a_read(32'h8000_0080, e, 5, "rd_after_rst");
        checks++;
        if (a_cnt !== 16'd1) begin errors++; $display("FAIL midrst_count got %0d want 1", a_cnt); end
    endtask

    initial begin
        a_pkt = '0; a_pkt_v = 1'b0; a_ready = 1'b0; a_data_i = '0; a_data_v_i = 1'b0;
        b_pkt = '0; b_pkt_v = 1'b0; b_ready = 1'b0; b_data_i = '0; b_data_v_i = 1'b0;
        c_pkt = '0; c_pkt_v = '0;   c_ready = '0;   c_data_i = '0; c_data_v_i = '0;
        test_reset();
        test_write_read();
        test_unaligned();
        test_lat0_stall();
        test_round_robin();
        test_range();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
